// File: rtl/xip_line_cache.sv
// Direct-mapped, read-only line cache in front of the SPI flash controller.
// Reads hit local storage or trigger a word-0-upward line fill; writes pass through and invalidate everything.
module xip_line_cache #(
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_value_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_value_o,
  output logic        mem_req_valid_o,
  output logic [31:0] mem_req_addr_o,
  output logic [31:0] mem_req_value_o,
  output logic        mem_req_wstrb_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_value_i
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - OFF - IDX;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL_REQ, FILL_WAIT, DONE, WR_REQ, WR_WAIT
  } state_e;

  state_e            state_q;
  logic [29:0]       addr_q;
  logic [OFF-1:0]    cnt_q;
  logic              flushed_q;
  logic [LINES-1:0]  valid_q;
  logic [31:0]       resp_hold_q;
  logic              mem_req_valid_q;
  logic [31:0]       mem_req_addr_q;
  logic [31:0]       mem_req_value_q;
  logic              mem_req_wstrb_q;

  logic [TAGW-1:0]   tag_mem  [LINES];
  logic [31:0]       data_mem [LINES][LINE_WORDS];

  logic [OFF-1:0]    word_w;
  logic [IDX-1:0]    index_w;
  logic [TAGW-1:0]   tag_w;
  logic              hit_w;
  logic              fill_last_w;
  logic [31:0]       line_word_w;
  logic              unused_addr_bits;

  assign word_w           = addr_q[OFF-1:0];
  assign index_w          = addr_q[OFF +: IDX];
  assign tag_w            = addr_q[29 -: TAGW];
  assign hit_w            = valid_q[index_w] && (tag_mem[index_w] == tag_w);
  assign fill_last_w      = (cnt_q == OFF'(LINE_WORDS - 1));
  assign line_word_w      = data_mem[index_w][word_w];
  assign unused_addr_bits = ^req_addr_i[1:0];

  assign req_ready_o     = (state_q == IDLE);
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign mem_req_value_o = mem_req_value_q;
  assign mem_req_wstrb_o = mem_req_wstrb_q;

  // Write responses are forwarded in the cycle they arrive, so the response port is a mux over a held value.
  always_comb begin
    resp_valid_o = 1'b0;
    resp_value_o = resp_hold_q;
    case (state_q)
      LOOKUP: begin
        if (hit_w) begin
          resp_valid_o = 1'b1;
          resp_value_o = line_word_w;
        end
      end
      DONE: begin
        resp_valid_o = 1'b1;
        resp_value_o = line_word_w;
      end
      WR_WAIT: begin
        if (mem_resp_valid_i) begin
          resp_valid_o = 1'b1;
          resp_value_o = mem_resp_value_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      flushed_q       <= 1'b0;
      valid_q         <= '0;
      resp_hold_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_value_q <= '0;
      mem_req_wstrb_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q <= req_addr_i[31:2];
            if (|req_wstrb_i) begin
              state_q         <= WR_REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_req_value_q <= req_value_i;
              mem_req_wstrb_q <= 1'b1;
            end else begin
              state_q <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          if (hit_w) begin
            resp_hold_q <= line_word_w;
            state_q     <= IDLE;
          end else begin
            cnt_q             <= '0;
            flushed_q         <= flush_i;
            valid_q[index_w]  <= 1'b0;
            mem_req_valid_q   <= 1'b1;
            mem_req_addr_q    <= {addr_q[29:OFF], {OFF{1'b0}}, 2'b00};
            mem_req_value_q   <= '0;
            mem_req_wstrb_q   <= 1'b0;
            state_q           <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          flushed_q <= flushed_q | flush_i;
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          flushed_q <= flushed_q | flush_i;
          if (mem_resp_valid_i) begin
            if (fill_last_w) begin
              if (!flushed_q) valid_q[index_w] <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q           <= cnt_q + OFF'(1);
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {addr_q[29:OFF], cnt_q + OFF'(1), 2'b00};
              state_q         <= FILL_REQ;
            end
          end
        end
        DONE: begin
          resp_hold_q <= line_word_w;
          state_q     <= IDLE;
        end
        WR_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_resp_valid_i) begin
            resp_hold_q <= mem_resp_value_i;
            valid_q     <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A flush always wins, including over the valid set at the end of a fill.
      if (flush_i) valid_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == FILL_WAIT && mem_resp_valid_i) begin
      data_mem[index_w][cnt_q] <= mem_resp_value_i;
      if (fill_last_w) tag_mem[index_w] <= tag_w;
    end
  end

endmodule

// File: tb/tb_xip_line_cache.sv
// Scoreboard bench for xip_line_cache with a behavioural flash model (read data = word address).
module tb_xip_line_cache;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_value_i;
  logic [3:0]  req_wstrb_i;
  logic        req_ready_o;
  logic        resp_valid_o;
  logic [31:0] resp_value_o;
  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_value_o;
  logic        mem_req_wstrb_o;
  logic        mem_req_ready_i;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_value_i;

  xip_line_cache #(.LINES(8), .LINE_WORDS(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_addr_i       (req_addr_i),
    .req_value_i      (req_value_i),
    .req_wstrb_i      (req_wstrb_i),
    .req_ready_o      (req_ready_o),
    .resp_valid_o     (resp_valid_o),
    .resp_value_o     (resp_value_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_value_o  (mem_req_value_o),
    .mem_req_wstrb_o  (mem_req_wstrb_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_value_i (mem_resp_value_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] val;
    int          acc;
    bit          hit;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] wr_val_log[$];
  logic        wr_strb_log[$];
  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          cyc          = 0;
  int          rd_cnt       = 0;
  int          wr_cnt       = 0;
  int          resp_cnt     = 0;
  bit          ready_en     = 1'b1;
  bit          stray_req    = 1'b0;

  assign mem_req_ready_i = ready_en;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Flash model: accepts when valid && ready, answers two cycles later; reads return the address.
  initial begin
    bit          pending;
    int          dly;
    logic [31:0] pval;
    pending          = 1'b0;
    dly              = 0;
    pval             = '0;
    mem_resp_valid_i = 1'b0;
    mem_resp_value_i = '0;
    forever begin
      @(negedge clk_i);
      #1;
      mem_resp_valid_i = 1'b0;
      if (!rst_ni) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          dly--;
          if (dly == 0) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_value_i = pval;
            pending          = 1'b0;
          end
        end else if (stray_req) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_value_i = 32'hBAD0_0BAD;
          stray_req        = 1'b0;
        end
        if (mem_req_valid_o && mem_req_ready_i && !pending) begin
          pending = 1'b1;
          dly     = 2;
          if (mem_req_wstrb_o) begin
            wr_cnt++;
            wr_val_log.push_back(mem_req_value_o);
            wr_strb_log.push_back(mem_req_wstrb_o);
            pval = ~mem_req_value_o;
          end else begin
            rd_cnt++;
            rd_log.push_back(mem_req_addr_o);
            pval = mem_req_addr_o;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && resp_valid_o) begin
        resp_cnt++;
        $display("resp  value=0x%08h cycle=%0d", resp_value_o, cyc);
        if (sb_q.size() == 0) begin
          check_val("unexpected_resp", {31'd0, resp_valid_o}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("resp_value", resp_value_o, e.val);
          if (e.hit) check_val("hit_latency", cyc, e.acc);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [31:0] val, input logic [3:0] strb,
                       input logic [31:0] expv, input bit hit, output int acc);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) check_val("ready_timeout", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_value_i = val;
    req_wstrb_i = strb;
    @(posedge clk_i);
    #1;
    acc   = cyc;
    e.val = expv;
    e.acc = acc;
    e.hit = hit;
    sb_q.push_back(e);
    $display("req   addr=0x%08h wstrb=%b value=0x%08h expect=0x%08h cycle=%0d", addr, strb, val, expv, acc);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_wstrb_i = 4'b0000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    if (sb_q.size() != 0) begin
      check_val("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input bit hit);
    int base;
    int acc;
    base = rd_cnt;
    issue(addr, 32'd0, 4'b0000, {addr[31:2], 2'b00}, hit, acc);
    drain();
    check_val(hit ? "hit_no_fill" : "miss_fill_cnt", rd_cnt - base, hit ? 32'd0 : 32'd4);
  endtask

  task automatic wait_rd(input int target);
    int n;
    n = 0;
    while (rd_cnt < target && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (rd_cnt < target) check_val("wait_fill_timeout", rd_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"},      {31'd0, req_ready_o},     32'd1);
    check_val({tag, "_resp_valid"}, {31'd0, resp_valid_o},    32'd0);
    check_val({tag, "_resp_value"}, resp_value_o,             32'd0);
    check_val({tag, "_mreq_valid"}, {31'd0, mem_req_valid_o}, 32'd0);
    check_val({tag, "_mreq_addr"},  mem_req_addr_o,           32'd0);
    check_val({tag, "_mreq_value"}, mem_req_value_o,          32'd0);
    check_val({tag, "_mreq_wstrb"}, {31'd0, mem_req_wstrb_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    int base;
    int rc;
    int n;
    logic [31:0] held;
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_value_i = '0;
    req_wstrb_i = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Cold read: four sequential word reads from the line base.
    rd_log.delete();
    do_read(32'h0000_0104, 1'b0);
    for (int i = 0; i < 4; i++) check_val("fill_order", rd_log[i], 32'h100 + 32'(4 * i));

    // Hits, including back-to-back at the maximum rate.
    do_read(32'h0000_0108, 1'b1);
    base = rd_cnt;
    issue(32'h0000_0100, 32'd0, 4'b0000, 32'h100, 1'b1, a0);
    issue(32'h0000_010C, 32'd0, 4'b0000, 32'h10C, 1'b1, a1);
    check_val("b2b_accept_gap", a1 - a0, 32'd2);
    drain();
    check_val("b2b_no_fill", rd_cnt - base, 32'd0);

    // Conflict on index 0.
    do_read(32'h0000_0300, 1'b0);
    rd_log.delete();
    do_read(32'h0000_0100, 1'b0);
    check_val("refill_first_addr", rd_log[0], 32'h100);

    // Write-through invalidates.
    base = rd_cnt;
    rc   = wr_cnt;
    issue(32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, ~32'hDEAD_BEEF, 1'b0, a0);
    drain();
    check_val("wr_count", wr_cnt - rc, 32'd1);
    check_val("wr_value", wr_val_log[0], 32'hDEAD_BEEF);
    check_val("wr_flag", {31'd0, wr_strb_log[0]}, 32'd1);
    check_val("wr_no_read", rd_cnt - base, 32'd0);
    do_read(32'h0000_0104, 1'b0);

    // Flush during the second fill word.
    base = rd_cnt;
    issue(32'h0000_0200, 32'd0, 4'b0000, 32'h200, 1'b0, a0);
    wait_rd(base + 2);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    drain();
    check_val("flushed_fill_cnt", rd_cnt - base, 32'd4);
    do_read(32'h0000_0200, 1'b0);

    // Downstream stall: request must hold steady.
    ready_en = 1'b0;
    base = rd_cnt;
    issue(32'h0000_0400, 32'd0, 4'b0000, 32'h400, 1'b0, a0);
    n = 0;
    while (!mem_req_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    held = mem_req_addr_o;
    check_val("stall_addr", held, 32'h400);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_val("stall_valid", {31'd0, mem_req_valid_o}, 32'd1);
      check_val("stall_addr_stable", mem_req_addr_o, 32'h400);
    end
    ready_en = 1'b1;
    drain();
    check_val("stall_fill_cnt", rd_cnt - base, 32'd4);

    // Stray flash response in IDLE is ignored.
    rc = resp_cnt;
    stray_req = 1'b1;
    repeat (4) @(negedge clk_i);
    check_val("stray_resp", resp_cnt, rc);
    check_val("stray_ready", {31'd0, req_ready_o}, 32'd1);
    do_read(32'h0000_0404, 1'b1);

    // Reset in the middle of a fill.
    base = rd_cnt;
    issue(32'h0000_0500, 32'd0, 4'b0000, 32'h500, 1'b0, a0);
    wait_rd(base + 2);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    sb_q.delete();
    repeat (2) @(negedge clk_i);
    check_val("midfill_no_resp", {31'd0, resp_valid_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    do_read(32'h0000_0500, 1'b0);
    do_read(32'h0000_050C, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/xip_line_cache.md
Name: xip_line_cache

Overview:
- Read-optimised, direct-mapped line cache between the CPU instruction/data fetch port and `flash_controller`.
- Turns CPU word requests into hits, served from local storage, or into line fills made of sequential single-word flash reads, so repeated XIP fetches avoid the slow SPI transaction.
- Writes pass straight through to the flash controller and invalidate the whole cache.

Parameters:
- LINES, 8, number of cache lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  invalidate all lines (level-sensitive)
- req_valid_i  in  1  CPU request valid
- req_addr_i  in  32  CPU byte address; bits [1:0] ignored
- req_value_i  in  32  CPU write data
- req_wstrb_i  in  4  byte strobes; any bit set = write
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
- resp_valid_o  out  1  one-cycle response pulse
- resp_value_o  out  32  response data
- mem_req_valid_o  out  1  flash request valid
- mem_req_addr_o  out  32  flash byte address, word-aligned
- mem_req_value_o  out  32  flash write data
- mem_req_wstrb_o  out  1  flash write flag
- mem_req_ready_i  in  1  flash controller accepts request
- mem_resp_valid_i  in  1  flash response pulse
- mem_resp_value_i  in  32  flash response data

Behaviour:
Reset values:
- Reset is async active-low. All valid bits = 0, state = IDLE.
- req_ready_o = 1; resp_valid_o = 0; resp_value_o = 0; mem_req_valid_o = 0; mem_req_addr_o = 0; mem_req_value_o = 0; mem_req_wstrb_o = 0.

Address split:
- OFF = log2(LINE_WORDS), IDX = log2(LINES).
- word = addr[2 +: OFF], index = addr[2+OFF +: IDX], tag = addr[31 : 2+OFF+IDX].
- Storage: data array, tag array and valid bit per line. Flops are acceptable.

State machine:
- IDLE: req_ready_o = 1. On accept, latch addr, value and write flag (|req_wstrb_i). Next state: WR_REQ if write, else LOOKUP.
- LOOKUP: hit = valid[index] && tag match.
  - Hit: resp_valid_o = 1, resp_value_o = data[index][word]; next state IDLE. Hit latency is 1 cycle after accept; maximum rate is one request per 2 cycles.
  - Miss: fill counter = 0, clear valid[index], go to FILL_REQ.
- FILL_REQ: mem_req_valid_o = 1, mem_req_addr_o = {tag, index, cnt, 2'b00}, mem_req_wstrb_o = 0. Hold all mem_req_* stable until mem_req_ready_i; then go to FILL_WAIT.
- FILL_WAIT: on mem_resp_valid_i, write data[index][cnt].
  - If cnt == LINE_WORDS-1: set tag[index], set valid[index] unless a flush was seen during the fill, go to DONE.
  - Otherwise cnt++ and go to FILL_REQ.
  - Fill order is always word 0 upward; there is no critical-word-first.
- DONE: resp_valid_o = 1, resp_value_o = data[index][word]; next state IDLE. Latency holds even if the fill was flushed.
- WR_REQ: mem_req_valid_o = 1, mem_req_addr_o = {addr[31:2], 2'b00}, mem_req_value_o = latched value, mem_req_wstrb_o = 1. On mem_req_ready_i go to WR_WAIT.
- WR_WAIT: on mem_resp_valid_i, resp_valid_o = 1, resp_value_o = mem_resp_value_i (same cycle), clear all valid bits, go to IDLE.

Rules:
- req_ready_o = 0 in every state except IDLE. Only one downstream request is outstanding at a time.
- mem_resp_valid_i is ignored outside FILL_WAIT and WR_WAIT. The downstream never responds in the same cycle it accepts.
- flush_i in any cycle clears all valid bits at the next edge.
  - During a fill, a sticky flag suppresses the final valid set. The in-flight request still completes and returns correct data.
  - flush_i in LOOKUP does not change that cycle's hit decision.
- No CPU backpressure on responses: resp_valid_o is a single-cycle pulse.
- resp_value_o holds its last value when resp_valid_o = 0.
- Reset mid-fill or mid-write: immediate return to IDLE, partial line discarded, no response. The downstream must be reset together with this block.

Test Plan:
1. Cold read 0x0000_0104, LINES=8, LINE_WORDS=4, flash word = address → four mem reads 0x100, 0x104, 0x108, 0x10C in order; resp_value_o = 0x0000_0104 in DONE.
2. Read 0x108 after test 1 → no mem_req_valid_o; resp_valid_o one cycle after accept with 0x108. Back-to-back reads 0x100, 0x10C are both hits, accepted every 2 cycles.
3. Conflict: read 0x100, then 0x300 (same index 0, new tag), then 0x100 → misses, 4 fills each; the third read refills from 0x100.
4. Write 0x104, value 0xDEAD_BEEF, wstrb 4'b0011 → one mem request with wstrb = 1 and value 0xDEAD_BEEF; resp mirrors mem_resp_value_i; next read of 0x104 misses.
5. Assert flush_i during the second fill word of a miss on 0x200 → resp returns the correct data; the immediate re-read of 0x200 misses and refills.
6. mem_req_ready_i held low 5 cycles in FILL_REQ → mem_req_addr_o stable; stray mem_resp_valid_i in IDLE is ignored. rst_ni low mid-fill → outputs at reset values, no resp_valid_o, a re-read misses.
